// File: rtl/zoechip_seg_decoder.sv
// Recovers a 4-bit nibble from an 8-bit segment word once it has been stable for STABLE_CYCLES valid samples.
// Accept is registered on the qualifying edge, so strobes appear the following cycle. There is no backpressure: samples arrive on in_valid.
module zoechip_seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] seg_in,
    output logic [3:0] nibble,
    output logic       out_valid,
    output logic       code_err,
    output logic [7:0] err_count
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
    localparam bit         ONE_SHOT = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     state, next_state;
    logic [7:0] last_seg, next_last_seg;
    logic [7:0] cnt, next_cnt;
    logic       accept;

    // Segment bit positions: A=1 B=6 C=2 D=7 F=4 G=5 M=3
    logic seg_a, seg_b, seg_c, seg_d, seg_f, seg_g, seg_m;
    logic word_ok;
    logic [3:0] decoded;

    assign seg_a = seg_in[1];
    assign seg_b = seg_in[6];
    assign seg_c = seg_in[2];
    assign seg_d = seg_in[7];
    assign seg_f = seg_in[4];
    assign seg_g = seg_in[5];
    assign seg_m = seg_in[3];

    assign word_ok = (seg_a == (seg_d ^ seg_m)) && (seg_b == (seg_f ^ seg_c)) &&
                     (seg_g == seg_f) && !seg_in[0];
    assign decoded = {seg_m, seg_c ^ seg_d, seg_m ^ seg_f ^ seg_d, seg_f ^ seg_d ^ seg_c};

    always_comb begin
        next_state    = state;
        next_last_seg = last_seg;
        next_cnt      = cnt;
        accept        = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    next_last_seg = seg_in;
                    next_cnt      = 8'd1;
                    accept        = ONE_SHOT;
                    next_state    = ONE_SHOT ? HOLD : SETTLE;
                end
                SETTLE: begin
                    if (seg_in == last_seg) begin
                        next_cnt = (cnt >= STABLE) ? cnt : cnt + 8'd1;
                        if (cnt + 8'd1 == STABLE) begin
                            accept     = 1'b1;
                            next_state = HOLD;
                        end
                    end else begin
                        next_last_seg = seg_in;
                        next_cnt      = 8'd1;
                        accept        = ONE_SHOT;
                        next_state    = ONE_SHOT ? HOLD : SETTLE;
                    end
                end
                HOLD: begin
                    // A repeated word in HOLD is deliberately not re-emitted
                    if (seg_in != last_seg) begin
                        next_last_seg = seg_in;
                        next_cnt      = 8'd1;
                        accept        = ONE_SHOT;
                        next_state    = ONE_SHOT ? HOLD : SETTLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_seg  <= 8'd0;
            cnt       <= 8'd0;
            nibble    <= 4'd0;
            out_valid <= 1'b0;
            code_err  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state     <= next_state;
            last_seg  <= next_last_seg;
            cnt       <= next_cnt;
            out_valid <= accept && word_ok;
            code_err  <= accept && !word_ok;
            if (accept && word_ok) begin
                nibble <= decoded;
            end
            if (accept && !word_ok && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/zoechip_seg_decoder.md
# zoechip_seg_decoder

Receive-side counterpart of the chip's nibble-to-segment encoder: it takes the 8-bit segment word produced by that encoder and recovers the original 4-bit nibble.

- **Filtering:** a word is accepted only after it has held stable for a programmable number of valid samples.
- **Checking:** every accepted word is tested against the encoder's parity relations. A passing word produces a one-cycle result strobe; a failing word produces an error strobe and increments a saturating error counter.
- **Placement:** used for loopback self-test and for reading back a segment bus.

## Interface

Parameters:
- STABLE_CYCLES, default 4: number of consecutive identical valid samples required before a word is accepted. Legal range 1..255.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: seg_in is sampled on this edge.
- seg_in, input, 8: segment word. Bit map: [1]=A, [6]=B, [2]=C, [7]=D, [4]=F, [5]=G, [3]=M, [0]=unused (legal value 0).
- nibble, output, 4: last successfully decoded value; held between accepts.
- out_valid, output, 1: one-cycle strobe, high when nibble has just been updated.
- code_err, output, 1: one-cycle strobe, high when an accepted word failed the checks.
- err_count, output, 8: number of failed accepts, saturating at 255.

## Operation

Decode equations (^ = XOR):
- nibble[0] = F^D^C
- nibble[1] = M^F^D
- nibble[2] = C^D
- nibble[3] = M

Check equations. A word passes only if all four hold:
- A == D^M
- B == F^C
- G == F
- seg_in[0] == 0

Internal registers:
- last_seg[7:0]: the most recent sampled word.
- cnt[7:0]: count of consecutive identical samples, saturating at STABLE_CYCLES.
- state: one of IDLE, SETTLE, HOLD.

State machine. All transitions occur only on edges where in_valid=1. On in_valid=0 edges, state, cnt and last_seg hold and both strobes are 0.
- **IDLE:** on a sample, set last_seg<=seg_in and cnt<=1. If STABLE_CYCLES==1, accept immediately and go to HOLD; otherwise go to SETTLE.
- **SETTLE, seg_in == last_seg:** cnt<=cnt+1. If cnt+1 == STABLE_CYCLES, accept and go to HOLD.
- **SETTLE, seg_in != last_seg:** set last_seg<=seg_in and cnt<=1, remain in SETTLE. If STABLE_CYCLES==1, accept and go to HOLD instead.
- **HOLD, seg_in == last_seg:** no action; the word is not re-emitted.
- **HOLD, seg_in != last_seg:** treat as a new first sample: last_seg<=seg_in, cnt<=1, go to SETTLE. If STABLE_CYCLES==1, accept and stay in HOLD.

Accept action (registered, on the same edge that triggers it):
- Word passes: nibble<=decode(seg_in), out_valid<=1.
- Word fails: code_err<=1, err_count<=min(err_count+1, 255), nibble unchanged.
- out_valid and code_err are never high together.

Reset values: nibble=0, out_valid=0, code_err=0, err_count=0, state=IDLE, cnt=0, last_seg=0.

## Timing

- **Latency:** with in_valid held high and seg_in constant from edge k, the accept occurs at edge k+STABLE_CYCLES-1. out_valid or code_err is high for exactly the following cycle.
- **Gaps:** in_valid=0 gaps do not break stability; only sampled edges count.
- **Pattern change mid-SETTLE:** restarts the count at 1; no strobe is produced for the abandoned word.
- **Repeated words:** the same word held indefinitely in HOLD produces exactly one strobe. Returning to a word after a different word has been sampled requires a fresh settle.
- **Error-counter saturation:** at 255 the counter stays at 255, and code_err still pulses on each further failure.
- **Reset:** rst_n low at any time (including mid-SETTLE, or during a strobe cycle) clears all outputs within the same cycle, without waiting for a clock. The first edge after release behaves as IDLE.
- **Combinational paths:** none from inputs to outputs.

## Test plan

1. **Reset.** Assert rst_n=0 mid-SETTLE with err_count=3 → all outputs read 0 immediately; after release, seg_in=0xB6 for 4 valid cycles → out_valid pulses once with nibble=1.
2. **Full sweep.** STABLE_CYCLES=4. Drive each encoder output for nibble 0..15, each held 4 valid cycles (e.g. 0x00→0, 0xCC→8, 0x4E→F) → exactly 16 out_valid pulses, each pulse on the 4th edge of its word, each with the matching nibble, code_err never high.
3. **Glitch rejection.** Drive 0xB6 ×2, 0xCC ×1, 0xB6 ×4 → a single out_valid pulse, nibble=1, occurring on the 7th sample; no strobe for 0xCC.
4. **Valid gaps and hold.** Drive 0xCC on valid cycles interleaved with in_valid=0 cycles, 4 valid samples total → one pulse, nibble=8; then 20 more valid cycles of 0xCC → no further pulses.
5. **Code errors.** Drive 0x01 (bit0 set) and 0x02 (A only), each held 4 cycles → two code_err pulses, err_count=2, nibble unchanged. Repeat with 260 alternating bad words → err_count saturates at 255.
6. **STABLE_CYCLES=1.** Drive 0x00, 0xB6, 0xB6, 0x4E on consecutive edges → out_valid high on the cycles after edges 1, 2 and 4, with nibble=0, 1, F; no strobe for the repeated 0xB6.
